// File: rtl/arbiter.sv
// Round-robin bus arbiter with a registered one-hot grant and a rotating priority pointer.
// Optional macro ARBITER_PARK_EN: idle cycles keep the last grant (bus parking) instead of clearing it.
module arbiter #(
    parameter int MANAGERS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [MANAGERS-1:0] requestV,
    output logic [MANAGERS-1:0] grantedV
);

    localparam int            PW   = (MANAGERS > 1) ? $clog2(MANAGERS) : 1;
    localparam logic [PW-1:0] LAST = PW'(MANAGERS - 1);

    logic [PW-1:0]       ptr_q, ptr_d;
    logic [MANAGERS-1:0] grant_q, grant_d;

    // Walk upward from ptr_q with an explicit wrap so non-power-of-two sizes never index past LAST.
    always_comb begin
        logic [PW-1:0] idx;
        logic          found;
`ifdef ARBITER_PARK_EN
        grant_d = grant_q;
`else
        grant_d = '0;
`endif
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int k = 0; k < MANAGERS; k++) begin
            if (!found && requestV[idx]) begin
                found        = 1'b1;
                grant_d      = '0;
                grant_d[idx] = 1'b1;
                ptr_d        = (idx == LAST) ? '0 : idx + 1'b1;
            end
            idx = (idx == LAST) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    assign grantedV = grant_q;

endmodule

// File: tb/tb_arbiter.sv
// Bench for arbiter: 4- and 3-manager instances against a behavioural round-robin model,
// with literal sequences pinning the model and randomized requests plus mid-cycle reset pulses.
module tb_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req4;
    logic [2:0] req3;
    logic [3:0] g4;
    logic [2:0] g3;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model state
    int          m_ptr4, m_ptr3;
    logic [15:0] m_g4, m_g3;

    arbiter #(.MANAGERS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .requestV(req4), .grantedV(g4));
    arbiter #(.MANAGERS(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .requestV(req3), .grantedV(g3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void arb_model(input int m, input logic [15:0] req, input int ptr_in,
                                      input logic [15:0] g_in, output int ptr_out,
                                      output logic [15:0] g_out);
        logic [15:0] mask;
        bit          hit;
        mask    = (16'h1 << m) - 16'h1;
        ptr_out = ptr_in;
        hit     = 1'b0;
`ifdef ARBITER_PARK_EN
        g_out = g_in;
`else
        g_out = 16'h0;
`endif
        if ((req & mask) != 16'h0) begin
            for (int k = 0; k < m; k++) begin
                int i;
                i = (ptr_in + k) % m;
                if (!hit && req[i]) begin
                    hit     = 1'b1;
                    g_out   = 16'h1 << i;
                    ptr_out = (i + 1) % m;
                end
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr4 = 0;
            m_ptr3 = 0;
            m_g4   = 16'h0;
            m_g3   = 16'h0;
        end else begin
            int          p;
            logic [15:0] g;
            arb_model(4, {12'h0, req4}, m_ptr4, m_g4, p, g);
            m_ptr4 = p;
            m_g4   = g;
            arb_model(3, {13'h0, req3}, m_ptr3, m_g3, p, g);
            m_ptr3 = p;
            m_g3   = g;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if ({12'h0, g4} !== m_g4) begin
                bad++;
                $display("FAIL model4 t=%0t got=%b exp=%b", $time, g4, m_g4[3:0]);
            end
            total++;
            if ({13'h0, g3} !== m_g3) begin
                bad++;
                $display("FAIL model3 t=%0t got=%b exp=%b", $time, g3, m_g3[2:0]);
            end
            total++;
            if ($countones(g4) > 1 || $countones(g3) > 1 || $isunknown({g4, g3})) begin
                bad++;
                $display("FAIL onehot t=%0t got4=%b got3=%b exp=at-most-one-bit", $time, g4, g3);
            end
        end
    end

    task automatic lit(input string name, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] r4, input logic [2:0] r3);
        req4 = r4;
        req3 = r3;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        #1;
        rst_n = 1'b0;
        #1;
        lit("async_rst4", g4, 4'b0000);
        lit("async_rst3", {1'b0, g3}, 4'b0000);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] seq4 [5];
        logic [2:0] seq3 [4];
        logic [3:0] alt  [4];
        rst_n = 1'b0;
        req4  = 4'b1111;
        req3  = 3'b111;
        seq4  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seq3  = '{3'b001, 3'b010, 3'b100, 3'b001};
        alt   = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        #2;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        lit("in_reset4", g4, 4'b0000);
        lit("in_reset3", {1'b0, g3}, 4'b0000);
        rst_n = 1'b1;

        // all-request rotation, including wrap at 3
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 3'b111);
            lit("rot4", g4, seq4[i]);
            if (i < 4) lit("rot3", {1'b0, g3}, {1'b0, seq3[i]});
        end

        // ptr=1, alternating two requesters
        for (int i = 0; i < 4; i++) begin
            step(4'b1010, 3'b000);
            lit("alt1010", g4, alt[i]);
        end

        for (int i = 0; i < 5; i++) begin
            step(4'b0001, 3'b001);
            lit("sole0001", g4, 4'b0001);
        end
        step(4'b0011, 3'b000);
        lit("pair_a", g4, 4'b0010);
        step(4'b0011, 3'b000);
        lit("pair_b", g4, 4'b0001);

        step(4'b0100, 3'b000);
        lit("grant0100", g4, 4'b0100);
        step(4'b0000, 3'b000);
`ifdef ARBITER_PARK_EN
        lit("idle_park", g4, 4'b0100);
`else
        lit("idle_zero", g4, 4'b0000);
`endif
        step(4'b1011, 3'b000);
        lit("after_idle", g4, 4'b1000);

        step(4'b0100, 3'b000);
        lit("pre_rst", g4, 4'b0100);
        req4 = 4'b1111;
        reset_pulse();
        step(4'b1111, 3'b111);
        lit("post_rst4", g4, 4'b0001);
        lit("post_rst3", {1'b0, g3}, 4'b0001);

        // randomized traffic with varying density and occasional reset pulses
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] r4;
            logic [2:0] r3;
            int dens;
            dens = $urandom_range(0, 3);
            r4 = 4'($urandom);
            r3 = 3'($urandom);
            if (dens == 0) begin
                r4 = r4 & 4'($urandom);
                r3 = r3 & 3'($urandom);
            end else if (dens == 1) begin
                r4 = r4 | 4'($urandom);
                r3 = r3 | 3'($urandom);
            end else if (dens == 2 && $urandom_range(0, 3) == 0) begin
                r4 = 4'b0000;
                r3 = 3'b000;
            end
            req4 = r4;
            req3 = r3;
            if ($urandom_range(0, 199) == 0) reset_pulse();
            step(r4, r3);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arbiter.md
ARBITER -- requirements
Module: arbiter

Interface
REQ-001 Parameter MANAGERS, default 4; number of requesting managers; SHALL be supported for any value from 2 to 16, power of two or not.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 requestV  input  MANAGERS  request vector; bit i high = manager i requests the bus.
REQ-005 grantedV  output  MANAGERS  grant vector; at most one bit high; bit i high = manager i owns the bus.
REQ-006 Port order SHALL be clk, rst_n, requestV, grantedV.

Function
REQ-007 The arbiter SHALL be round-robin, with a priority pointer ptr (0..MANAGERS-1) naming the highest-priority manager.
REQ-008 On each rising clk edge with any requestV bit high, grantedV SHALL become one-hot at the first requesting index found searching upward from ptr, wrapping from MANAGERS-1 to 0.
REQ-009 On the same edge, ptr SHALL become (granted index + 1) mod MANAGERS, wrapping correctly for non-power-of-two MANAGERS.
REQ-010 On a rising edge with requestV all zero, grantedV SHALL become all zero and ptr SHALL hold, unless ARBITER_PARK_EN is defined (REQ-017).
REQ-011 grantedV SHALL be registered: requestV sampled at edge N appears on grantedV after edge N; there is no combinational path from requestV to grantedV.
REQ-012 Re-arbitration SHALL occur every cycle; a continuously requesting grantee SHALL lose the grant on the next edge if any other manager is requesting (no hold or lock).
REQ-013 A sole requester SHALL receive the grant on every edge for as long as it requests.
REQ-014 grantedV SHALL never have more than one bit high, including with X-free all-ones requests and directly after reset.
REQ-015 With every bit of requestV high, grants SHALL cycle 0,1,...,MANAGERS-1,0,... one index per clock.

Reset
REQ-016 While rst_n is low, grantedV SHALL be all zero and ptr SHALL be 0, asynchronously; arbitration SHALL resume on the first rising clk edge after rst_n goes high, including when reset is asserted mid-stream.

Configuration
REQ-017 Macro ARBITER_PARK_EN: when defined, a cycle with no requests SHALL keep grantedV at the last granted one-hot value (bus parking) and ptr unchanged; grantedV SHALL still be zero after reset until the first grant. When not defined, REQ-010 applies (all-zero grant when idle).

Verification
REQ-018 MANAGERS=4, requestV=1111 held through reset release -> grantedV 0000 during reset, then 0001, 0010, 0100, 1000, 0001 on successive edges.
REQ-019 After a grant of 0001 (ptr=1), requestV=1010 -> grantedV 0010, 1000, 0010, 1000.
REQ-020 requestV=0001 held for 5 cycles -> grantedV 0001 every cycle; then requestV=0011 -> grantedV 0010, then 0001.
REQ-021 After a grant of 0100, requestV=0000 -> grantedV 0000 without ARBITER_PARK_EN and 0100 with it; then requestV=1011 -> grantedV 1000.
REQ-022 Asynchronous rst_n pulse between edges while grantedV=0100 -> grantedV 0000 immediately; with requestV=1111, the next edge after release gives grantedV=0001.
REQ-023 MANAGERS=3, requestV=111 -> grantedV 001, 010, 100, 001 (wrap at 3); one-hot is checked on every cycle of every test.
